seg_scan: RTL

SEG_SCAN -- requirements
Module: seg_scan

---
 rtl/seg_scan_if.sv | 22 ++
 rtl/seg_scan.sv | 137 +++++++++++++
 2 files changed

// File: rtl/seg_scan_if.sv
// Bundles the display scanner's stimulus inputs and cathode/anode outputs.
// The master side drives the inputs; seg_scan takes the slave side.
interface seg_scan_if;
  logic        div_clock;
  logic        enable;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        frame_pulse;

  modport master (
    output div_clock, enable, value, dp,
    input  an, seg, dp_n, frame_pulse
  );

  modport slave (
    input  div_clock, enable, value, dp,
    output an, seg, dp_n, frame_pulse
  );
endinterface

// File: rtl/seg_scan.sv
// Four-digit multiplexed seven-segment scanner with guard gaps between digits,
// per-frame value shadowing and optional leading-zero blanking.
module seg_scan #(
  parameter int unsigned GUARD_CYCLES  = 4,
  parameter int unsigned BLANK_LEADING = 1
) (
  input logic        clock,
  input logic        reset,
  seg_scan_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StGuard, StDrive} state_e;

  localparam logic [3:0] GuardLast = 4'(GUARD_CYCLES - 1);

  state_e      state_q;
  logic [1:0]  idx_q;
  logic [3:0]  gcnt_q;
  logic [15:0] shadow_q;
  logic        s1_q, s2_q, s3_q;
  logic [3:0]  an_q;
  logic [6:0]  seg_q;
  logic        dp_n_q;
  logic        frame_pulse_q;

  logic        scan_tick;
  logic [3:0]  cur_digit;
  logic [15:0] upper_digits;
  logic        blank;

  function automatic logic [6:0] decode(input logic [3:0] d);
    unique case (d)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction

  always_comb begin
    scan_tick    = s2_q & ~s3_q;
    cur_digit    = shadow_q[{idx_q, 2'b00} +: 4];
    // Current digit together with every digit above it.
    upper_digits = shadow_q >> {idx_q, 2'b00};
    blank        = (BLANK_LEADING != 0) && (idx_q != 2'd0) && (upper_digits == 16'h0000);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      idx_q         <= 2'd0;
      gcnt_q        <= 4'd0;
      shadow_q      <= 16'h0000;
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      s3_q          <= 1'b0;
      an_q          <= 4'hF;
      seg_q         <= 7'h7F;
      dp_n_q        <= 1'b1;
      frame_pulse_q <= 1'b0;
    end else begin
      s1_q          <= bus.div_clock;
      s2_q          <= s1_q;
      s3_q          <= s2_q;
      frame_pulse_q <= 1'b0;
      if (!bus.enable) begin
        state_q <= StIdle;
        an_q    <= 4'hF;
        seg_q   <= 7'h7F;
        dp_n_q  <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (scan_tick) begin
              state_q       <= StGuard;
              idx_q         <= 2'd0;
              gcnt_q        <= 4'd0;
              shadow_q      <= bus.value;
              frame_pulse_q <= 1'b1;
            end
          end
          StGuard: begin
            // Ticks arriving here are intentionally discarded.
            if (gcnt_q == GuardLast) begin
              state_q <= StDrive;
              gcnt_q  <= 4'd0;
              if (blank) begin
                an_q   <= 4'hF;
                seg_q  <= 7'h7F;
                dp_n_q <= 1'b1;
              end else begin
                an_q   <= ~(4'b0001 << idx_q);
                seg_q  <= decode(cur_digit);
                dp_n_q <= ~bus.dp[idx_q];
              end
            end else begin
              gcnt_q <= gcnt_q + 4'd1;
            end
          end
          StDrive: begin
            if (scan_tick) begin
              state_q <= StGuard;
              idx_q   <= idx_q + 2'd1;
              gcnt_q  <= 4'd0;
              an_q    <= 4'hF;
              seg_q   <= 7'h7F;
              dp_n_q  <= 1'b1;
              if (idx_q == 2'd3) begin
                shadow_q      <= bus.value;
                frame_pulse_q <= 1'b1;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.dp_n        = dp_n_q;
  assign bus.frame_pulse = frame_pulse_q;

endmodule
